dmiss_ctrl: RTL

DMISS_CTRL -- requirements
Module: dmiss_ctrl

---
 rtl/mem_pkg.sv | 30 +++
 rtl/store_align.sv | 19 +
 rtl/dmiss_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-side miss controller: FSM states,
// store size codes and the per-size byte-enable table.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } dmiss_state_e;

    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;
    localparam logic [2:0] SZ_D = 3'd3;

    // Byte enables for a right-justified access of the given size.
    function automatic logic [7:0] size_strb(input logic [2:0] size);
        case (size)
            SZ_B:    size_strb = 8'h01;
            SZ_H:    size_strb = 8'h03;
            SZ_W:    size_strb = 8'h0F;
            SZ_D:    size_strb = 8'hFF;
            default: size_strb = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/store_align.sv
// Moves right-justified store data and its byte enables into the byte
// lanes selected by the low address bits of a 64-bit bus word.
module store_align
    import mem_pkg::*;
(
    input  logic [2:0]  addr_lo_i,
    input  logic [2:0]  size_i,
    input  logic [63:0] data_i,
    output logic [63:0] data_o,
    output logic [7:0]  strb_o
);

    // Lane shift; bytes pushed past lane 7 are dropped.
    always_comb begin
        data_o = data_i << {addr_lo_i, 3'b000};
        strb_o = size_strb(size_i) << addr_lo_i;
    end

endmodule

// File: rtl/dmiss_ctrl.sv
// Data-cache miss controller: one outstanding request at a time, either a
// full line refill over the read channels or a single write-through store
// over the write channels.
module dmiss_ctrl
    import mem_pkg::*;
#(
    parameter int B  = 8,
    parameter int AW = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 miss_req,
    input  logic [AW-1:0]        miss_addr,
    input  logic                 miss_write,
    input  logic [2:0]           miss_size,
    input  logic [63:0]          miss_data,
    output logic                 miss_busy,
    output logic                 miss_done,
    output logic                 fill_valid,
    output logic [$clog2(B)-1:0] fill_idx,
    output logic [63:0]          fill_data,
    output logic [AW-1:0]        fill_tag_addr,
    output logic                 ar_valid,
    input  logic                 ar_ready,
    output logic [AW-1:0]        ar_addr,
    output logic [7:0]           ar_len,
    input  logic                 r_valid,
    output logic                 r_ready,
    input  logic [63:0]          r_data,
    input  logic                 r_last,
    output logic                 aw_valid,
    input  logic                 aw_ready,
    output logic [AW-1:0]        aw_addr,
    output logic [2:0]           aw_size,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [63:0]          w_data,
    output logic [7:0]           w_strb,
    output logic                 w_last,
    input  logic                 b_valid,
    output logic                 b_ready
);

    localparam int IW    = $clog2(B);
    localparam int OFF_W = $clog2(8 * B);
    localparam logic [AW-1:0] LINE_MASK = ~((AW'(1) << OFF_W) - AW'(1));

    dmiss_state_e  state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    size_q, size_d;
    logic [63:0]   data_q, data_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;

    logic [AW-1:0] line_addr;
    logic [63:0]   al_data;
    logic [7:0]    al_strb;
    logic          aw_hs, w_hs;

    assign line_addr = addr_q & LINE_MASK;
    assign aw_hs     = (state_q == WR_REQ) && !aw_done_q && aw_ready;
    assign w_hs      = (state_q == WR_REQ) && !w_done_q && w_ready;

    store_align u_align (
        .addr_lo_i (addr_q[2:0]),
        .size_i    (size_q),
        .data_i    (data_q),
        .data_o    (al_data),
        .strb_o    (al_strb)
    );

    // Next-state and output decode; every output is forced low while reset
    // is asserted so the bus sees nothing from an aborted transaction.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        size_d        = size_q;
        data_d        = data_q;
        cnt_d         = cnt_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        miss_busy     = 1'b0;
        miss_done     = 1'b0;
        fill_valid    = 1'b0;
        fill_idx      = '0;
        fill_data     = '0;
        fill_tag_addr = '0;
        ar_valid      = 1'b0;
        ar_addr       = '0;
        ar_len        = '0;
        r_ready       = 1'b0;
        aw_valid      = 1'b0;
        aw_addr       = '0;
        aw_size       = '0;
        w_valid       = 1'b0;
        w_data        = '0;
        w_strb        = '0;
        w_last        = 1'b0;
        b_ready       = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    // The load/store decision is carried by the next state,
                    // so the write flag itself need not be kept.
                    if (miss_req) begin
                        addr_d    = miss_addr;
                        size_d    = miss_size;
                        data_d    = miss_data;
                        cnt_d     = '0;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = miss_write ? WR_REQ : RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    miss_busy = 1'b1;
                    ar_valid  = 1'b1;
                    ar_addr   = line_addr;
                    ar_len    = 8'(B - 1);
                    if (ar_ready) begin
                        cnt_d   = '0;
                        state_d = RD_DATA;
                    end
                end
                RD_DATA: begin
                    miss_busy = 1'b1;
                    r_ready   = 1'b1;
                    if (r_valid) begin
                        fill_valid    = 1'b1;
                        fill_idx      = cnt_q;
                        fill_data     = r_data;
                        fill_tag_addr = line_addr;
                        cnt_d         = cnt_q + IW'(1);
                        // The burst ends on r_last, whatever the beat count.
                        if (r_last) begin
                            state_d = DONE;
                        end
                    end
                end
                WR_REQ: begin
                    miss_busy = 1'b1;
                    aw_valid  = !aw_done_q;
                    w_valid   = !w_done_q;
                    w_last    = !w_done_q;
                    aw_addr   = addr_q;
                    aw_size   = size_q;
                    w_data    = al_data;
                    w_strb    = al_strb;
                    if (aw_hs) begin
                        aw_done_d = 1'b1;
                    end
                    if (w_hs) begin
                        w_done_d = 1'b1;
                    end
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        state_d = WR_RESP;
                    end
                end
                WR_RESP: begin
                    miss_busy = 1'b1;
                    b_ready   = 1'b1;
                    if (b_valid) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    miss_done = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, latched request and beat counter; reset clears the latched
    // fields too so address/data outputs read zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule
